mem_stage_param: RTL
====================

Name: mem_stage_param

Overview:
Parametrised successor to the pipeline MEM stage. It maps the ALU address into a word index and holds a DEPTH-word data memory. Accesses take a configurable number of wait states, and the block stalls the pipeline through a freeze output while an access is in flight. It sits between EXE/MEM and MEM/WB; its freeze output is ORed into the hazard/freeze logic of the upstream pipeline registers.

Parameters:
DATA_W, 32, data/address width in bits (power of 2, >= 16)
DEPTH, 64, number of DATA_W-bit words (power of 2)
BASE_ADDR, 1024, byte address mapped to word index 0
LATENCY, 0, wait cycles per access (0..15); an access occupies LATENCY+1 cycles

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
MEM_R_EN_in  in  1  load request
MEM_W_EN_in  in  1  store request
ALU_result_in  in  DATA_W  byte address
ST_val  in  DATA_W  store data
Mem_read_value  out  DATA_W  load data
freeze  out  1  stall request to pipeline, combinational

Behaviour:
- Address mapping:
  - off = ALU_result_in - BASE_ADDR (DATA_W-bit wrap).
  - idx = off >> log2(DATA_W/8), truncated to log2(DEPTH) bits.
  - The low log2(DATA_W/8) bits are ignored.
- Request: req = MEM_R_EN_in | MEM_W_EN_in. If both are high, the access is a write and the read is ignored.
- FSM states IDLE and BUSY; 4-bit counter cnt.
- IDLE, req=0: freeze=0; stays in IDLE.
- IDLE, req=1, LATENCY=0: completion cycle. freeze=0; write commits at the edge; stays in IDLE.
- IDLE, req=1, LATENCY>0: freeze=1; next state BUSY, cnt<=1.
- BUSY, cnt<LATENCY: freeze=1; cnt<=cnt+1.
- BUSY, cnt==LATENCY: completion cycle. freeze=0; write commits at the edge; next state IDLE, cnt<=0.
- Back-to-back accesses: a new request in the cycle after a completion starts a fresh access. There is no pipelining of accesses.
- Inputs must stay stable while freeze=1 (upstream is frozen).
- Abort: if req drops while in BUSY (e.g. flush), go to IDLE and set cnt<=0. No write occurs and the read-hold register is unchanged.
- Memory: written only at a completion-cycle edge of a write access, with mem[idx]<=ST_val. Memory is not cleared by rst.
- Mem_read_value:
  - During the completion cycle of a read, equals mem[idx] (combinational from the array).
  - At that edge, a hold register captures the value.
  - In all other cycles, equals the hold register.
- Read-during-write: not possible, since only one access is in flight at a time.
- Reset: state=IDLE, cnt=0, hold register=0, so Mem_read_value=0. freeze=0 unless a request is present while LATENCY>0. Reset mid-access abandons the access with no write.

Optional Feature:
Macro MEM_ADDR_CHECK_EN.
- Defined:
  - Adds output port addr_fault (1 bit, combinational).
  - addr_fault is high during any cycle of an access where: ALU_result_in < BASE_ADDR (unsigned), or the unmasked word index >= DEPTH, or the low log2(DATA_W/8) bits are nonzero.
  - On a faulting access, the write is suppressed and the read returns 0, both in the completion cycle and in the hold register.
  - Timing and freeze behaviour are unchanged.
- Undefined: no addr_fault port; the address wraps modulo DEPTH and misalignment is silently ignored.

Test Plan:
1. LATENCY=0: write ALU=1024, ST=0xDEADBEEF; next cycle read ALU=1024 -> Mem_read_value=0xDEADBEEF in the same cycle; freeze never high.
2. LATENCY=2: read request at cycle t -> freeze=1 at t and t+1, freeze=0 at t+2 with data valid; Mem_read_value holds that value at t+3 with req=0.
3. LATENCY=2: both enables high, ALU=1028, ST=0x5 -> after 3 cycles mem[1]=0x5; a subsequent read of 1028 returns 0x5.
4. LATENCY=3: write to 1032 with req dropped at 2nd BUSY cycle -> FSM returns to IDLE, and a later read of 1032 returns the previous content.
5. LATENCY=2: rst asserted for one cycle mid-read -> next cycle state IDLE, Mem_read_value=0, freeze low once req=0.
6. MEM_ADDR_CHECK_EN, DEPTH=64: write ALU=1024+256 (idx 64) or ALU=1026 -> addr_fault=1, memory unchanged; read ALU=1000 -> addr_fault=1, Mem_read_value=0.

Source files
------------

// File: rtl/mem_stage_param.sv
// Purpose : pipeline MEM stage with a DEPTH-word data memory and LATENCY wait states per access.
// Latency : an access occupies LATENCY+1 cycles; load data is valid combinationally in the completion cycle, then held.
// Backpressure: freeze is raised in every non-completion cycle of an access so that upstream holds its inputs.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   MEM_R_EN_in      load request
//   MEM_W_EN_in      store request (wins over a simultaneous load)
//   ALU_result_in    byte address; BASE_ADDR maps to word index 0
//   ST_val           store data
//   Mem_read_value   load data (combinational in completion cycle, held otherwise)
//   freeze           combinational stall request to the pipeline
//   addr_fault       only when MEM_ADDR_CHECK_EN is defined: out-of-range or misaligned access
//
// Optional feature macro: MEM_ADDR_CHECK_EN. When it is undefined the index wraps modulo
// DEPTH and the low byte-offset bits are ignored.
module mem_stage_param #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 64,
    parameter int BASE_ADDR = 1024,
    parameter int LATENCY   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_R_EN_in,
    input  logic              MEM_W_EN_in,
    input  logic [DATA_W-1:0] ALU_result_in,
    input  logic [DATA_W-1:0] ST_val,
    output logic [DATA_W-1:0] Mem_read_value,
    output logic              freeze
`ifdef MEM_ADDR_CHECK_EN
    ,
    output logic              addr_fault
`endif
);

    localparam int                BYTE_SH = $clog2(DATA_W / 8);
    localparam int                IDX_W   = $clog2(DEPTH);
    localparam logic [DATA_W-1:0] BASE    = DATA_W'(BASE_ADDR);
    localparam logic [DATA_W-1:0] DEPTH_W = DATA_W'(DEPTH);
    localparam logic [3:0]        LAT     = 4'(LATENCY);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              req;
    logic              done;
    logic              fault;
    logic              wr_commit;
    logic              rd_commit;
    logic [DATA_W-1:0] off;
    logic [DATA_W-1:0] word;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rd_data;
    logic              unused_addr;

    assign req  = MEM_R_EN_in | MEM_W_EN_in;
    assign off  = ALU_result_in - BASE;
    assign word = off >> BYTE_SH;
    assign idx  = word[IDX_W-1:0];
    // Upper index bits only matter to the range check; the sink keeps the default build quiet.
    assign unused_addr = ^{off, word};

`ifdef MEM_ADDR_CHECK_EN
    assign fault = req & ((ALU_result_in < BASE) |
                          (word >= DEPTH_W) |
                          (ALU_result_in[BYTE_SH-1:0] != '0));
    assign addr_fault = fault;
`else
    assign fault = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        freeze  = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (LAT == 4'd0) begin
                        done = 1'b1;
                    end else begin
                        freeze  = 1'b1;
                        state_d = BUSY;
                        cnt_d   = 4'd1;
                    end
                end
            end
            BUSY: begin
                if (!req) begin
                    // Request withdrawn (flush): abandon without touching memory or hold.
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q < LAT) begin
                    freeze = 1'b1;
                    cnt_d  = cnt_q + 4'd1;
                end else begin
                    done    = 1'b1;
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Store has priority, so a dual-enable access never updates the hold register.
    assign wr_commit = done & MEM_W_EN_in & ~fault & ~rst;
    assign rd_commit = done & MEM_R_EN_in & ~MEM_W_EN_in;
    assign rd_data   = fault ? '0 : mem[idx];

    assign Mem_read_value = rd_commit ? rd_data : hold_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (rd_commit) begin
                hold_q <= rd_data;
            end
        end
    end

    // Array has no reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            mem[idx] <= ST_val;
        end
    end

endmodule
